// File: rtl/spawn_pkg.sv
// Shared state type, default timing constants and the round-robin wrap helper
// for the lane spawner.
package spawn_pkg;

    typedef enum logic [0:0] {
        S_SCAN  = 1'b0,
        S_OFFER = 1'b1
    } spawnState_t;

    localparam int DEFAULT_MIN_GAP   = 16;
    localparam int DEFAULT_GAP_SHIFT = 2;
    localparam int DEFAULT_TIMER_W   = 8;

    // Lane pointers travel through the helper at this width (up to 16 lanes).
    localparam int PTR_W = 4;

    function automatic logic [PTR_W-1:0] next_lane(input logic [PTR_W-1:0] ptr,
                                                  input int numLanes);
        if (int'(ptr) == numLanes - 1) begin
            return '0;
        end
        return ptr + 4'd1;
    endfunction

endpackage

// File: rtl/lane_timer.sv
// Per-lane frame countdown: decrements on each tick, saturates at zero and
// raises a sticky pending flag when it expires; a load overrides everything.
module lane_timer
    import spawn_pkg::*;
#(
    parameter int TIMER_W = DEFAULT_TIMER_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_loadVal,
    input  logic [TIMER_W-1:0] i_initVal,
    output logic               o_pending,
    output logic [TIMER_W-1:0] o_count
);

    logic [TIMER_W-1:0] r_count;
    logic               r_pending;

    // A load on the same cycle as a tick wins, so the reloaded gap is not
    // shortened by one frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count   <= i_initVal;
            r_pending <= 1'b0;
        end else if (i_load) begin
            r_count   <= i_loadVal;
            r_pending <= 1'b0;
        end else if (i_tick && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
            if (r_count == TIMER_W'(1)) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_count   = r_count;

endmodule

// File: rtl/lane_spawner.sv
// Spawn scheduler: one countdown timer per road lane, round-robin arbitration of
// expired lanes and a valid/ready offer to the car-slot allocator.
module lane_spawner
    import spawn_pkg::*;
#(
    parameter int NUM_LANES = 8,
    parameter int MIN_GAP   = DEFAULT_MIN_GAP,
    parameter int GAP_SHIFT = DEFAULT_GAP_SHIFT,
    parameter int TIMER_W   = DEFAULT_TIMER_W
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_frameTick,
    input  logic                         i_enable,
    input  logic [3:0]                   i_rand,
    output logic                         o_spawnValid,
    input  logic                         i_spawnReady,
    output logic [$clog2(NUM_LANES)-1:0] o_spawnLane,
    output logic                         o_spawnDir,
    output logic [2:0]                   o_spawnSpeed,
    output logic [NUM_LANES-1:0]         o_pending
);

    localparam int LANE_W = $clog2(NUM_LANES);

    logic [3:0]         r_randMeta;
    logic [3:0]         r_randS;

    spawnState_t        r_state;
    logic [LANE_W-1:0]  r_ptr;
    logic               r_spawnValid;
    logic [LANE_W-1:0]  r_spawnLane;
    logic               r_spawnDir;
    logic [2:0]         r_spawnSpeed;

    logic               w_tick;
    logic               w_accept;
    logic [TIMER_W-1:0] w_reloadVal;
    logic [LANE_W-1:0]  w_nextPtr;
    logic [LANE_W-1:0]  w_laneAfter;
    logic [NUM_LANES-1:0] w_load;
    logic [NUM_LANES-1:0] w_pending;
    logic [TIMER_W-1:0] w_count [NUM_LANES];

    // The random nibble comes from another timing domain; only the second
    // flop is ever consumed.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_randMeta <= '0;
            r_randS    <= '0;
        end else begin
            r_randMeta <= i_rand;
            r_randS    <= r_randMeta;
        end
    end

    assign w_tick      = i_frameTick & i_enable;
    assign w_accept    = r_spawnValid & i_spawnReady;
    assign w_reloadVal = TIMER_W'(MIN_GAP) + (TIMER_W'(r_randS) << GAP_SHIFT);
    assign w_nextPtr   = LANE_W'(next_lane(PTR_W'(r_ptr), NUM_LANES));
    assign w_laneAfter = LANE_W'(next_lane(PTR_W'(r_spawnLane), NUM_LANES));

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        assign w_load[gi] = w_accept && (r_spawnLane == LANE_W'(gi));

        lane_timer #(
            .TIMER_W (TIMER_W)
        ) u_timer (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_tick    (w_tick),
            .i_load    (w_load[gi]),
            .i_loadVal (w_reloadVal),
            .i_initVal (TIMER_W'(MIN_GAP + gi)),
            .o_pending (w_pending[gi]),
            .o_count   (w_count[gi])
        );

        // A lane can only be waiting for a spawn once its countdown is spent.
        always @(posedge i_clk) begin
            if (!i_rst && w_pending[gi]) begin
                assert (w_count[gi] == '0);
            end
        end
    end

    // Scan walks the pointer one lane per cycle; once an offer is made its
    // fields stay frozen until the allocator takes it, even if Enable drops.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_SCAN;
            r_ptr        <= '0;
            r_spawnValid <= 1'b0;
            r_spawnLane  <= '0;
            r_spawnDir   <= 1'b0;
            r_spawnSpeed <= '0;
        end else begin
            case (r_state)
                S_SCAN: begin
                    if (w_pending[r_ptr] && i_enable) begin
                        r_spawnLane  <= r_ptr;
                        r_spawnDir   <= r_ptr[0];
                        r_spawnSpeed <= 3'd1 + {1'b0, r_randS[1:0]};
                        r_spawnValid <= 1'b1;
                        r_state      <= S_OFFER;
                    end else begin
                        r_ptr <= w_nextPtr;
                    end
                end
                S_OFFER: begin
                    if (i_spawnReady) begin
                        r_spawnValid <= 1'b0;
                        r_ptr        <= w_laneAfter;
                        r_state      <= S_SCAN;
                    end
                end
                default: begin
                    r_state      <= S_SCAN;
                    r_spawnValid <= 1'b0;
                end
            endcase
        end
    end

    assign o_spawnValid = r_spawnValid;
    assign o_spawnLane  = r_spawnLane;
    assign o_spawnDir   = r_spawnDir;
    assign o_spawnSpeed = r_spawnSpeed;
    assign o_pending    = w_pending;

endmodule
